// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: load/store unit on a word-wide req/ack bus plus the MEM/WB register.
// Loads are lane-aligned and extended; stores get byte enables and replicated data.

module mem_stage_lsu_lane #(
  parameter int IDX = 0
) (
  input  logic        en,
  input  logic [1:0]  size,
  input  logic [63:0] src,
  output logic [7:0]  wbyte
);
  // Byte lane IDX takes store byte (IDX mod access size); size 3 wraps the mask to 7.
  logic [2:0] sel;
  assign sel   = 3'(IDX) & ((3'd1 << size) - 3'd1);
  assign wbyte = en ? src[{sel, 3'b000} +: 8] : 8'h00;
endmodule

module mem_stage_lsu #(
  parameter int WORD_BITWIDTH    = 32,
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          memRead,
  input  logic                          memWrite,
  input  logic                          memToReg,
  input  logic [2:0]                    funct3,
  input  logic [REG_NUM_BITWIDTH-1:0]   rd,
  input  logic [WORD_BITWIDTH-1:0]      ALUresult,
  input  logic [WORD_BITWIDTH-1:0]      readData2,
  output logic                          stall,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [WORD_BITWIDTH-1:0]      mem_addr,
  output logic [WORD_BITWIDTH/8-1:0]    mem_be,
  output logic [WORD_BITWIDTH-1:0]      mem_wdata,
  input  logic [WORD_BITWIDTH-1:0]      mem_rdata,
  input  logic                          mem_ack,
  output logic                          wb_valid,
  output logic [WORD_BITWIDTH-1:0]      wb_data,
  output logic [REG_NUM_BITWIDTH-1:0]   wb_rd,
  output logic                          wb_memToReg,
  output logic                          misaligned_exc,
  output logic                          timeout_exc,
  output logic [WORD_BITWIDTH-1:0]      exc_addr
);
  localparam int W  = WORD_BITWIDTH;
  localparam int NB = W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [0:0] IDLE = 1'b0, ACCESS = 1'b1;

  typedef struct packed {
    logic [W-1:0]                addr;
    logic [W-1:0]                wdata;
    logic [REG_NUM_BITWIDTH-1:0] rd;
    logic                        we;
    logic                        m2r;
    logic                        uns;
    logic [1:0]                  size;
  } op_t;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  op_t           op;
  logic          acc, memop, legal, misal, bad, tmo;
  logic [LB-1:0] lane_in;

  assign acc     = (state == ACCESS);
  assign memop   = memRead | memWrite;
  assign lane_in = ALUresult[LB-1:0];

  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~memWrite;
      3'b011:                 legal = (W == 64);
      3'b110:                 legal = (W == 64) && !memWrite;
      default:                legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   misal = lane_in[0];
      2'b10:   misal = |lane_in[1:0];
      2'b11:   misal = |lane_in;
      default: misal = 1'b0;
    endcase
  end

  assign bad   = ~legal | misal;
  // Ack in the final allowed cycle still completes the access.
  assign tmo   = (TIMEOUT_CYCLES != 0) && (cnt == TMAX) && !mem_ack;
  assign stall = acc ? ~mem_ack : (in_valid & memop & ~bad);

  // Bus side: everything is forced to zero outside ACCESS.
  logic [7:0]         szmask, be8;
  logic [NB-1:0][7:0] wbytes;

  always_comb begin
    case (op.size)
      2'd0:    szmask = 8'h01;
      2'd1:    szmask = 8'h03;
      2'd2:    szmask = 8'h0F;
      default: szmask = 8'hFF;
    endcase
  end

  assign be8       = szmask << op.addr[LB-1:0];
  assign mem_req   = acc;
  assign mem_we    = acc & op.we;
  assign mem_addr  = acc ? {op.addr[W-1:LB], {LB{1'b0}}} : '0;
  assign mem_be    = acc ? be8[NB-1:0] : '0;
  assign mem_wdata = wbytes;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    mem_stage_lsu_lane #(.IDX(i)) u_lane (
      .en    (acc & op.we),
      .size  (op.size),
      .src   (64'(op.wdata)),
      .wbyte (wbytes[i])
    );
  end

  // Load alignment: shift lane down, then mask and extend by size.
  logic [W-1:0] sh, msk, ld;
  logic         sgn;

  assign sh = mem_rdata >> {op.addr[LB-1:0], 3'b000};

  always_comb begin
    msk = '1;
    sgn = 1'b0;
    case (op.size)
      2'd0:    begin msk = W'(8'hFF);         sgn = sh[7];  end
      2'd1:    begin msk = W'(16'hFFFF);      sgn = sh[15]; end
      2'd2:    begin msk = W'(32'hFFFF_FFFF); sgn = sh[31]; end
      default: begin msk = '1;                sgn = 1'b0;   end
    endcase
    ld = (sh & msk) | ((sgn & ~op.uns) ? ~msk : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      op             <= '0;
      wb_valid       <= 1'b0;
      wb_data        <= '0;
      wb_rd          <= '0;
      wb_memToReg    <= 1'b0;
      misaligned_exc <= 1'b0;
      timeout_exc    <= 1'b0;
      exc_addr       <= '0;
    end else begin
      wb_valid       <= 1'b0;
      misaligned_exc <= 1'b0;
      timeout_exc    <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          if (!memop) begin
            wb_valid    <= 1'b1;
            wb_data     <= ALUresult;
            wb_rd       <= rd;
            wb_memToReg <= memToReg;
          end else if (bad) begin
            misaligned_exc <= 1'b1;
            exc_addr       <= ALUresult;
          end else begin
            op    <= '{addr: ALUresult, wdata: readData2, rd: rd, we: memWrite,
                       m2r: memToReg, uns: funct3[2], size: funct3[1:0]};
            cnt   <= '0;
            state <= ACCESS;
          end
        end
        default: begin
          if (mem_ack) begin
            wb_valid    <= 1'b1;
            wb_data     <= op.we ? op.addr : ld;
            wb_rd       <= op.rd;
            wb_memToReg <= op.m2r;
            state       <= IDLE;
          end else if (tmo) begin
            timeout_exc <= 1'b1;
            exc_addr    <= op.addr;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu (W=32, TIMEOUT_CYCLES=4): directed vector table, reset
// sequences, and random ops checked against an arithmetic model.

module tb_mem_stage_lsu;
  localparam int T = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 0, memRead = 0, memWrite = 0, memToReg = 0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] ALUresult = '0, readData2 = '0, mem_rdata = '0;
  logic        mem_ack = 0;
  logic        stall, mem_req, mem_we, wb_valid, wb_memToReg, misaligned_exc, timeout_exc;
  logic [31:0] mem_addr, mem_wdata, wb_data, exc_addr;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;

  mem_stage_lsu #(.WORD_BITWIDTH(32), .REG_NUM_BITWIDTH(5), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .funct3(funct3), .rd(rd), .ALUresult(ALUresult),
    .readData2(readData2), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_memToReg(wb_memToReg), .misaligned_exc(misaligned_exc),
    .timeout_exc(timeout_exc), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mr, mw, m2r;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, d2, rdata;
    int          ack_after;  // ACCESS cycles before ack; -1 = never
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    bit          e_bad;
  } vec_t;

  int pass_cnt = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(bit mr, bit mw, logic [2:0] f3, logic [31:0] addr, d2, rdata,
                              int ack, logic [31:0] ed, logic [3:0] eb, logic [31:0] ew, bit bad);
    vec_t v;
    v.mr = mr; v.mw = mw; v.m2r = mr; v.f3 = f3; v.rd = 5'd5; v.addr = addr; v.d2 = d2;
    v.rdata = rdata; v.ack_after = ack; v.e_data = ed; v.e_be = eb; v.e_wdata = ew;
    v.e_bad = bad;
    return v;
  endfunction

  // Reference model: plain arithmetic on sizes and byte offsets.
  function automatic bit m_bad(vec_t v);
    int sz;
    bit lg;
    if (!(v.mr || v.mw)) return 0;
    lg = (v.f3 inside {3'd0, 3'd1, 3'd2}) || (v.f3 inside {3'd4, 3'd5} && !v.mw);
    if (!lg) return 1;
    sz = 1 << v.f3[1:0];
    return (int'(v.addr % 4) % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] rdata, logic [31:0] addr, logic [2:0] f3);
    longint unsigned val, lim;
    int sz, lane;
    sz   = 1 << f3[1:0];
    lane = int'(addr % 4);
    lim  = 64'd1 << (8 * sz);
    val  = (longint'(rdata) >> (8 * lane)) % lim;
    if (!f3[2] && val >= lim / 2) val = val - lim;
    return val[31:0];
  endfunction

  function automatic logic [3:0] m_be(logic [31:0] addr, logic [2:0] f3);
    int m;
    m = ((1 << (1 << f3[1:0])) - 1) << int'(addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(logic [31:0] d2, logic [2:0] f3);
    logic [31:0] r, b;
    int sz;
    sz = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) begin
      b = d2 >> (8 * (i % sz));
      r[8*i +: 8] = b[7:0];
    end
    return r;
  endfunction

  task automatic run_op(input vec_t v);
    bit memop, done;
    int stalls;
    memop = v.mr || v.mw;
    done = 0;
    stalls = 0;
    in_valid = 1; memRead = v.mr; memWrite = v.mw; memToReg = v.m2r; funct3 = v.f3;
    rd = v.rd; ALUresult = v.addr; readData2 = v.d2;
    @(negedge clk);
    chk("idle_req", mem_req, 0);
    chk("idle_stall", stall, memop && !v.e_bad);
    if (stall) stalls++;
    @(posedge clk); #1;
    in_valid = 0; ALUresult = $urandom; readData2 = $urandom; funct3 = 3'($urandom);
    if (!memop) begin
      chk("alu_wb_valid", wb_valid, 1);
      chk("alu_wb_data", wb_data, v.e_data);
      chk("alu_wb_rd", wb_rd, v.rd);
      chk("alu_wb_m2r", wb_memToReg, v.m2r);
    end else if (v.e_bad) begin
      chk("mis_exc", misaligned_exc, 1);
      chk("mis_exc_addr", exc_addr, v.addr);
      chk("mis_wb_valid", wb_valid, 0);
      chk("mis_no_req", mem_req, 0);
    end else begin
      for (int k = 0; k < T && !done; k++) begin
        mem_ack   = (k == v.ack_after);
        mem_rdata = mem_ack ? v.rdata : $urandom;
        @(negedge clk);
        chk("acc_req", mem_req, 1);
        chk("acc_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        chk("acc_we", mem_we, v.mw);
        chk("acc_be", mem_be, v.e_be);
        if (v.mw) chk("acc_wdata", mem_wdata, v.e_wdata);
        if (stall) stalls++;
        @(posedge clk); #1;
        if (mem_ack) begin
          mem_ack = 0;
          done = 1;
          chk("ret_wb_valid", wb_valid, 1);
          chk("ret_wb_rd", wb_rd, v.rd);
          chk("ret_wb_m2r", wb_memToReg, v.m2r);
          chk("ret_no_tmo", timeout_exc, 0);
          if (!v.mw) chk("ld_data", wb_data, v.e_data);
        end else if (k == T - 1) begin
          done = 1;
          chk("tmo_exc", timeout_exc, 1);
          chk("tmo_exc_addr", exc_addr, v.addr);
          chk("tmo_wb_valid", wb_valid, 0);
          chk("tmo_req_drop", mem_req, 0);
        end else begin
          chk("acc_wb_valid", wb_valid, 0);
        end
      end
      mem_ack = 0;
      chk("stall_cycles", stalls, (v.ack_after < 0) ? 1 + T : 1 + v.ack_after);
    end
    @(posedge clk); #1;
    chk("post_wb_valid", wb_valid, 0);
    chk("post_mis", misaligned_exc, 0);
    chk("post_tmo", timeout_exc, 0);
    chk("post_req", mem_req, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int sel;

    tbl.push_back(mk(0, 0, 3'd0, 32'h1234, 0, 0, 0, 32'h1234, 4'h0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd0, 32'h103, 0, 32'h80FF_0000, 3, 32'hFFFF_FF80, 4'b1000, 0, 0));
    tbl.push_back(mk(1, 0, 3'd4, 32'h103, 0, 32'h80FF_0000, 3, 32'h0000_0080, 4'b1000, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 32'h6, 32'hABCD_1234, 0, 0, 0, 4'b1100, 32'h1234_1234, 0));
    tbl.push_back(mk(1, 0, 3'd2, 32'h2, 0, 0, 0, 0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 0, 3'd3, 32'h0, 0, 0, 0, 0, 4'h0, 0, 1));
    tbl.push_back(mk(0, 1, 3'd4, 32'h0, 32'h77, 0, 0, 0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 0, 3'd1, 32'h2, 0, 32'h8001_0000, 1, 32'hFFFF_8001, 4'b1100, 0, 0));
    tbl.push_back(mk(1, 0, 3'd5, 32'h2, 0, 32'h8001_0000, 1, 32'h0000_8001, 4'b1100, 0, 0));
    tbl.push_back(mk(1, 0, 3'd2, 32'h4, 0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 4'hF, 0, 0));
    tbl.push_back(mk(0, 1, 3'd0, 32'h1, 32'h1255, 0, 0, 0, 4'b0010, 32'h5555_5555, 0));
    tbl.push_back(mk(0, 1, 3'd2, 32'h8, 32'hCAFE_F00D, 0, 1, 0, 4'hF, 32'hCAFE_F00D, 0));
    tbl.push_back(mk(1, 0, 3'd2, 32'h10, 0, 0, -1, 0, 4'hF, 0, 0));
    tbl.push_back(mk(1, 0, 3'd1, 32'h1, 0, 0, 0, 0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 0, 3'd7, 32'h0, 0, 0, 0, 0, 4'h0, 0, 1));
    tbl.push_back(mk(1, 1, 3'd2, 32'hC, 32'h1122_3344, 0, 0, 0, 4'hF, 32'h1122_3344, 0));
    tbl.push_back(mk(0, 0, 3'd6, 32'hFFFF_0001, 0, 0, 0, 32'hFFFF_0001, 4'h0, 0, 0));

    // Reset state
    #12;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_exc_addr", exc_addr, 0);
    chk("rst_exc", {misaligned_exc, timeout_exc}, 0);
    @(posedge clk); #1;
    rst_n = 1;

    foreach (tbl[i]) run_op(tbl[i]);

    // Reset during ACCESS drops the request asynchronously.
    in_valid = 1; memRead = 1; memWrite = 0; funct3 = 3'd2; ALUresult = 32'h20; rd = 5'd9;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("mid_req_before", mem_req, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_be", mem_be, 0);
    @(posedge clk); #1;
    rst_n = 1;
    chk("mid_rst_wb_valid", wb_valid, 0);
    run_op(mk(1, 0, 3'd2, 32'h24, 0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 4'hF, 0, 0));

    // Random ops against the model
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      v.mr = (sel == 1) || (sel == 3);
      v.mw = (sel == 2) || (sel == 3);
      v.m2r = 1'($urandom);
      v.rd = 5'($urandom);
      v.f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (v.f3 != 3'd3 && !v.mw && $urandom_range(0, 1) == 1) v.f3[2] = (v.f3[1:0] != 2'd2);
      v.addr = $urandom;
      v.d2 = $urandom;
      v.rdata = $urandom;
      v.ack_after = $urandom_range(0, T);
      if (v.ack_after == T) v.ack_after = -1;
      v.e_bad = m_bad(v);
      v.e_data = (v.mr || v.mw) ? m_load(v.rdata, v.addr, v.f3) : v.addr;
      v.e_be = m_be(v.addr, v.f3);
      v.e_wdata = m_wdata(v.d2, v.f3);
      run_op(v);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
